fsm_key_provisioner: RTL
========================

Name: fsm_key_provisioner

Overview:
- Key-side counterpart of the team's key-locked benchmark FSMs, which consume a key bus on their keyinput ports.
- Receives a key serially over a valid/ready bit stream, checks its length and parity, and stages it in a shadow register.
- Commits a passing key to a stable key_out bus. Counts failed loads and enters a permanent lockout after too many.
- Sits between the test/provisioning port and one or more locked FSM instances.

Parameters:
KEY_W, 8, number of key bits delivered to the locked FSM (1..32)
MAX_FAIL, 3, consecutive failed loads that trigger LOCKOUT (1..15)
LOAD_TIMEOUT, 64, idle cycles allowed mid-load before the load is declared failed (>=2)

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
kin_valid  input  1  serial key bit valid
kin_ready  output  1  provisioner accepts a bit; a beat transfers when valid&&ready
kin_bit  input  1  key bit, MSB first, followed by one even-parity bit
kin_last  input  1  marks the parity bit (final beat of a load)
key_out  output  KEY_W  committed key driven to the locked FSM keyinput pins
key_valid  output  1  key_out holds a checked key
locked_out  output  1  LOCKOUT reached
busy  output  1  state is SHIFT or CHECK
fail_cnt  output  4  consecutive failed loads, saturating at MAX_FAIL

Behaviour:
- Reset, sampled on the clk edge: state=IDLE, key_out=0, key_valid=0, locked_out=0, fail_cnt=0, bit counter=0, timeout counter=0. Reset mid-load discards the partial key.
- States: IDLE, SHIFT, CHECK, APPLY, LOCKOUT.
- kin_ready=1 in IDLE and SHIFT only.
- IDLE:
  - An accepted beat loads the shadow register LSB with kin_bit, sets count=1, goes to SHIFT.
  - If kin_last is set on that beat, go to CHECK instead; it fails on length.
- SHIFT:
  - Each accepted beat increments count. The first KEY_W beats shift into the shadow register. Beat KEY_W+1 is the parity bit.
  - kin_last on an accepted beat -> CHECK next cycle.
  - Beat count reaching KEY_W+2 without kin_last -> CHECK next cycle with a length error; that beat's data is discarded.
  - Timeout counter clears on every accepted beat and increments otherwise. Reaching LOAD_TIMEOUT -> CHECK with a timeout error.
- CHECK (1 cycle): pass iff count==KEY_W+1, no timeout, and XOR(shadow, parity bit)==0.
  - Pass -> APPLY.
  - Fail -> fail_cnt+1. If the new value equals MAX_FAIL -> LOCKOUT, else IDLE.
- APPLY (1 cycle): key_out<=shadow, key_valid<=1, fail_cnt<=0, then IDLE.
- key_out is latency-locked: a passing load's parity beat is accepted in cycle N, and key_out/key_valid update at the end of cycle N+2.
- A failed load leaves key_out and key_valid unchanged. The previously committed key stays live, so the FSM never sees a partial key.
- LOCKOUT:
  - key_out forced to 0, key_valid=0, locked_out=1, kin_ready=0.
  - Exited only by rst.
- fail_cnt saturates and never wraps.
- kin_bit and kin_last are ignored when the beat does not transfer.

Optional Feature:
- Macro KEYPROV_ZEROIZE_EN.
- When defined:
  - Adds input port zeroize (1 bit).
  - zeroize=1 in any state except LOCKOUT clears key_out, key_valid, the shadow register and the counters on the next edge, and returns the block to IDLE.
  - fail_cnt is preserved.
  - zeroize takes priority over a simultaneous beat or CHECK.
- When undefined: the port is absent and behaviour is as above.

Test Plan:
- Good load (KEY_W=8): rst, then stream 1,0,1,0,0,1,0,1 followed by parity 0 with kin_last -> key_out=8'hA5 and key_valid=1 two cycles after the parity beat; fail_cnt=0.
- Bad parity: committed key 8'hA5, then stream 8'h3C with parity 1 -> key_out stays 8'hA5, fail_cnt=1, state returns to IDLE.
- Lockout: three consecutive bad-parity loads -> after the third CHECK, locked_out=1, key_out=0, key_valid=0, kin_ready=0; a fourth good load is not accepted; rst clears everything.
- Length errors:
  - kin_last on beat 5 -> fail_cnt increments.
  - 10 beats without kin_last -> CHECK after beat 10, fail.
  - key_out unchanged in both cases.
- Timeout and reset: send 4 bits, then hold kin_valid=0 for 64 cycles -> fail_cnt+1, back to IDLE. Separately, assert rst mid-SHIFT -> all outputs 0 on the next cycle.
- With KEYPROV_ZEROIZE_EN: committed 8'hA5 with fail_cnt=2; pulse zeroize -> key_out=0 and key_valid=0 next cycle, fail_cnt remains 2.

Source files
------------

// File: rtl/fsm_key_provisioner.sv
// Serial key loader: shifts a key in over a valid/ready bit stream, checks length and even parity,
// commits passing keys to key_out and locks out after MAX_FAIL consecutive failures. Option: KEYPROV_ZEROIZE_EN.
module fsm_key_provisioner #(
    parameter int KEY_W        = 8,
    parameter int MAX_FAIL     = 3,
    parameter int LOAD_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
`ifdef KEYPROV_ZEROIZE_EN
    input  logic             zeroize,
`endif
    input  logic             kin_valid,
    output logic             kin_ready,
    input  logic             kin_bit,
    input  logic             kin_last,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             locked_out,
    output logic             busy,
    output logic [3:0]       fail_cnt,
    output logic [2:0]       dbg_state
);

    localparam int CNT_W = $clog2(KEY_W + 3);
    localparam int TMO_W = $clog2(LOAD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_APPLY   = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    // Handshake: a beat transfers on a rising edge where kin_valid && kin_ready;
    // kin_bit/kin_last are only looked at on such beats, and kin_ready depends only on state.

    state_t             r_state;
    state_t             w_state_next;
    logic [KEY_W-1:0]   r_shadow;
    logic               r_parity;
    logic [CNT_W-1:0]   r_cnt;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_tmo_err;
    logic [KEY_W-1:0]   r_key_out;
    logic               r_key_valid;
    logic               r_locked;
    logic [3:0]         r_fail_cnt;

    logic               w_ready;
    logic               w_beat;
    logic               w_zero;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [TMO_W-1:0]   w_tmo_inc;
    logic [KEY_W-1:0]   w_shifted;
    logic               w_pass;
    logic [3:0]         w_fail_inc;
    logic               w_len_over;
    logic               w_tmo_hit;

`ifdef KEYPROV_ZEROIZE_EN
    assign w_zero = zeroize && (r_state != ST_LOCKOUT);
`else
    assign w_zero = 1'b0;
`endif

    assign w_ready    = (r_state == ST_IDLE) || (r_state == ST_SHIFT);
    assign w_beat     = kin_valid && w_ready;
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_tmo_inc  = r_tmo_cnt + TMO_W'(1);
    assign w_shifted  = (r_shadow << 1) | KEY_W'(kin_bit);
    assign w_len_over = (w_cnt_inc == CNT_W'(KEY_W + 2));
    assign w_tmo_hit  = (w_tmo_inc == TMO_W'(LOAD_TIMEOUT));
    assign w_pass     = (r_cnt == CNT_W'(KEY_W + 1)) && !r_tmo_err && !(^r_shadow ^ r_parity);
    assign w_fail_inc = (r_fail_cnt < 4'(MAX_FAIL)) ? r_fail_cnt + 4'd1 : r_fail_cnt;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_beat) w_state_next = kin_last ? ST_CHECK : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_beat) begin
                    if (kin_last || w_len_over) w_state_next = ST_CHECK;
                end else if (w_tmo_hit) begin
                    w_state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_pass)                           w_state_next = ST_APPLY;
                else if (w_fail_inc == 4'(MAX_FAIL))  w_state_next = ST_LOCKOUT;
                else                                  w_state_next = ST_IDLE;
            end
            ST_APPLY:   w_state_next = ST_IDLE;
            ST_LOCKOUT: w_state_next = ST_LOCKOUT;
            default:    w_state_next = ST_IDLE;
        endcase
        if (w_zero) w_state_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow    <= '0;
            r_parity    <= 1'b0;
            r_cnt       <= '0;
            r_tmo_cnt   <= '0;
            r_tmo_err   <= 1'b0;
            r_key_out   <= '0;
            r_key_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_fail_cnt  <= 4'd0;
        end else if (w_zero) begin
            // fail_cnt deliberately survives zeroize so it cannot be used to dodge lockout
            r_shadow    <= '0;
            r_parity    <= 1'b0;
            r_cnt       <= '0;
            r_tmo_cnt   <= '0;
            r_tmo_err   <= 1'b0;
            r_key_out   <= '0;
            r_key_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tmo_cnt <= '0;
                    r_tmo_err <= 1'b0;
                    if (w_beat) begin
                        r_shadow <= KEY_W'(kin_bit);
                        r_parity <= 1'b0;
                        r_cnt    <= CNT_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (w_beat) begin
                        r_cnt     <= w_cnt_inc;
                        r_tmo_cnt <= '0;
                        if (w_cnt_inc <= CNT_W'(KEY_W))          r_shadow <= w_shifted;
                        else if (w_cnt_inc == CNT_W'(KEY_W + 1)) r_parity <= kin_bit;
                    end else begin
                        r_tmo_cnt <= w_tmo_inc;
                        if (w_tmo_hit) r_tmo_err <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    r_cnt <= '0;
                    if (!w_pass) begin
                        r_fail_cnt <= w_fail_inc;
                        if (w_fail_inc == 4'(MAX_FAIL)) begin
                            r_key_out   <= '0;
                            r_key_valid <= 1'b0;
                            r_locked    <= 1'b1;
                        end
                    end
                end
                ST_APPLY: begin
                    r_key_out   <= r_shadow;
                    r_key_valid <= 1'b1;
                    r_fail_cnt  <= 4'd0;
                end
                ST_LOCKOUT: begin
                    r_key_out   <= '0;
                    r_key_valid <= 1'b0;
                    r_locked    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign kin_ready  = w_ready;
    assign key_out    = r_key_out;
    assign key_valid  = r_key_valid;
    assign locked_out = r_locked;
    assign busy       = (r_state == ST_SHIFT) || (r_state == ST_CHECK);
    assign fail_cnt   = r_fail_cnt;
    assign dbg_state  = r_state;

endmodule
